rns_residue_seq: RTL

RNS_RESIDUE_SEQ -- requirements
Module: rns_residue_seq

---
 rtl/rns_residue_seq.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/rns_residue_seq.sv
// Bit-serial residue generator: reduces x modulo {2^n-1, 2^n, 2^n+1, 2^(n+1)-1}
// with one shared shift-and-subtract reducer, one bit per cycle, one modulus after another.
module rns_residue_seq #(
  parameter int XW   = 32,
  parameter int NMAX = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [XW-1:0] x,
  input  logic [7:0]    n,
  input  logic          abort,
  output logic [NMAX:0] r1,
  output logic [NMAX:0] r2,
  output logic [NMAX:0] r3,
  output logic [NMAX:0] r4,
  output logic          err,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);

  localparam int RW = NMAX + 1;
  localparam int BW = (XW > 1) ? $clog2(XW) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state_q;
  logic [XW-1:0] x_q;
  logic [7:0]    n_q;
  logic [RW-1:0] acc_q;
  logic [1:0]    k_q;      // modulus index: 0 selects m1, 3 selects m4
  logic [BW-1:0] b_q;
  logic [RW-1:0] r_q [4];
  logic          err_q;
  logic          out_valid_q;
  logic          in_ready_q;
  logic          busy_q;

  logic [RW:0]   pow_w;
  logic [RW-1:0] mod_w [4];
  logic [RW-1:0] mod_sel;
  logic [RW:0]   t_w;
  logic [RW-1:0] acc_d;
  logic          n_legal;

  assign pow_w = (RW+1)'(1) << n_q;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_mod
      if (gi == 0) begin : g_m1
        assign mod_w[gi] = RW'(pow_w - 1'b1);
      end else if (gi == 1) begin : g_m2
        assign mod_w[gi] = RW'(pow_w);
      end else if (gi == 2) begin : g_m3
        assign mod_w[gi] = RW'(pow_w + 1'b1);
      end else begin : g_m4
        assign mod_w[gi] = RW'((pow_w << 1) - 1'b1);
      end
    end
  endgenerate

  // acc < m keeps t below 2m, so one conditional subtract restores acc < m
  always_comb begin
    mod_sel = mod_w[k_q];
    t_w     = {acc_q, x_q[b_q]};
    acc_d   = RW'(t_w);
    if (t_w >= {1'b0, mod_sel}) begin
      acc_d = RW'(t_w - {1'b0, mod_sel});
    end
  end

  assign n_legal = (n >= 8'd2) && (n <= 8'(NMAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      n_q         <= '0;
      acc_q       <= '0;
      k_q         <= 2'd0;
      b_q         <= BW'(XW - 1);
      for (int i = 0; i < 4; i++) r_q[i] <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q        <= x;
            n_q        <= n;
            acc_q      <= '0;
            k_q        <= 2'd0;
            b_q        <= BW'(XW - 1);
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (n_legal) begin
              state_q <= REDUCE;
              err_q   <= 1'b0;
            end else begin
              state_q     <= DONE;
              err_q       <= 1'b1;
              out_valid_q <= 1'b1;
              for (int i = 0; i < 4; i++) r_q[i] <= '0;
            end
          end
        end
        REDUCE: begin
          if (abort) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            k_q        <= 2'd0;
            b_q        <= BW'(XW - 1);
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end else if (b_q == '0) begin
            r_q[k_q] <= acc_d;
            acc_q    <= '0;
            b_q      <= BW'(XW - 1);
            k_q      <= k_q + 2'd1;
            if (k_q == 2'd3) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end
          end else begin
            acc_q <= acc_d;
            b_q   <= b_q - 1'b1;
          end
        end
        DONE: begin
          if (abort || out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign r1        = r_q[0];
  assign r2        = r_q[1];
  assign r3        = r_q[2];
  assign r4        = r_q[3];
  assign err       = err_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign busy      = busy_q;

endmodule
